// File: rtl/line_mem_bridge.sv
// -----------------------------------------------------------------------------
// line_mem_bridge
//
// Bridges a single-beat, 512-bit line request from an initiator onto a 32-bit
// backing store. A captured request is split into sixteen word beats, which
// are issued in ascending order (beat 0 = line bits [31:0]). Read beats are
// gathered into a line buffer. When the last beat is acknowledged the bridge
// spends one DONE cycle. In that cycle it pulses data_ready and, for a read,
// drives the assembled line on data_o.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   chip_select  responder selected by the initiator's upper-address decode
//   addr_valid   request strobe, sampled only while idle
//   addr         line byte address; bits [5:0] are the in-line offset and are
//                ignored
//   data_valid   request is a write
//   data_i       write line
//   data_ready   one-cycle completion pulse, high-Z otherwise
//   data_o       read line during a read completion cycle, high-Z otherwise
//   mem_req      backing-store beat request
//   mem_we       current beat is a write
//   mem_addr     current beat byte address
//   mem_wdata    current beat write data
//   mem_ack      backing store accepted/completed the beat this cycle
//   mem_rdata    read beat data, valid with mem_ack
// -----------------------------------------------------------------------------
module line_mem_bridge #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chip_select,
  input  logic              addr_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic              data_valid,
  input  logic [511:0]      data_i,
  output logic              data_ready,
  output logic [511:0]      data_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int LINE_W = ADDR_W - 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [3:0]        beat_r;
  logic [3:0]        beat_nx_s;
  logic [LINE_W-1:0] line_r;
  logic [LINE_W-1:0] line_nx_s;
  logic              is_wr_r;
  logic              is_wr_nx_s;
  logic [511:0]      wline_r;
  logic [511:0]      wline_nx_s;
  logic [511:0]      rbuf_r;

  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic              ready_r;
  logic              dout_en_r;

  logic              mem_req_nx_s;
  logic              mem_we_nx_s;
  logic [ADDR_W-1:0] mem_addr_nx_s;
  logic [31:0]       mem_wdata_nx_s;
  logic              ready_nx_s;
  logic              dout_en_nx_s;

  // The in-line byte offset plays no part in a whole-line transfer.
  logic              unused_addr_bits_s;
  assign unused_addr_bits_s = ^addr[5:0];

  // Picks 32-bit word idx out of a line (word 0 = bits [31:0]).
  function automatic logic [31:0] word_sel(input logic [511:0] line, input logic [3:0] idx);
    word_sel = line[{idx, 5'b00000} +: 32];
  endfunction

  // FSM state register together with the captured request context.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      beat_r  <= 4'd0;
      line_r  <= {LINE_W{1'b0}};
      is_wr_r <= 1'b0;
      wline_r <= {512{1'b0}};
    end else begin
      state_r <= state_nx_s;
      beat_r  <= beat_nx_s;
      line_r  <= line_nx_s;
      is_wr_r <= is_wr_nx_s;
      wline_r <= wline_nx_s;
    end
  end

  // Next-state logic: accept only while idle, advance one beat per ack.
  always_comb begin
    state_nx_s = state_r;
    beat_nx_s  = beat_r;
    line_nx_s  = line_r;
    is_wr_nx_s = is_wr_r;
    wline_nx_s = wline_r;
    case (state_r)
      ST_IDLE: begin
        if (chip_select && addr_valid) begin
          line_nx_s  = addr[ADDR_W-1:6];
          is_wr_nx_s = data_valid;
          wline_nx_s = data_i;
          beat_nx_s  = 4'd0;
          state_nx_s = data_valid ? ST_WR : ST_RD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RD, ST_WR: begin
        if (mem_ack) begin
          // The 4-bit counter wraps 15 -> 0 on the final ack; DONE stops
          // any further beats from being issued.
          beat_nx_s = beat_r + 4'd1;
          if (beat_r == 4'd15) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = state_r;
          end
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state. Once registered, every output depends
  // only on flops, so mem_req has no combinational path from mem_ack.
  always_comb begin
    mem_req_nx_s   = 1'b0;
    mem_we_nx_s    = 1'b0;
    mem_addr_nx_s  = {ADDR_W{1'b0}};
    mem_wdata_nx_s = 32'h0000_0000;
    ready_nx_s     = 1'b0;
    dout_en_nx_s   = 1'b0;
    case (state_nx_s)
      ST_RD: begin
        mem_req_nx_s  = 1'b1;
        mem_addr_nx_s = {line_nx_s, beat_nx_s, 2'b00};
      end
      ST_WR: begin
        mem_req_nx_s   = 1'b1;
        mem_we_nx_s    = 1'b1;
        mem_addr_nx_s  = {line_nx_s, beat_nx_s, 2'b00};
        mem_wdata_nx_s = word_sel(wline_nx_s, beat_nx_s);
      end
      ST_DONE: begin
        ready_nx_s   = 1'b1;
        dout_en_nx_s = !is_wr_nx_s;
      end
      ST_IDLE: begin
        mem_req_nx_s = 1'b0;
      end
      default: begin
        mem_req_nx_s = 1'b0;
      end
    endcase
  end

  // Registered outputs toward the backing store and the completion strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= 32'h0000_0000;
      ready_r     <= 1'b0;
      dout_en_r   <= 1'b0;
    end else begin
      mem_req_r   <= mem_req_nx_s;
      mem_we_r    <= mem_we_nx_s;
      mem_addr_r  <= mem_addr_nx_s;
      mem_wdata_r <= mem_wdata_nx_s;
      ready_r     <= ready_nx_s;
      dout_en_r   <= dout_en_nx_s;
    end
  end

  // Read line buffer: each acknowledged read beat lands in its word slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rbuf_r <= {512{1'b0}};
    end else if ((state_r == ST_RD) && mem_ack) begin
      rbuf_r[{beat_r, 5'b00000} +: 32] <= mem_rdata;
    end else begin
      rbuf_r <= rbuf_r;
    end
  end

  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  // Shared initiator return path: drive only in the completion cycle.
  assign data_ready = ready_r ? 1'b1 : 1'bz;
  assign data_o     = dout_en_r ? rbuf_r : {512{1'bz}};

endmodule

// File: tb/tb_line_mem_bridge.sv
module tb_line_mem_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         chip_select;
  logic         addr_valid;
  logic [13:0]  addr;
  logic         data_valid;
  logic [511:0] data_i;
  wire          data_ready;
  wire  [511:0] data_o;
  logic         mem_req;
  logic         mem_we;
  logic [13:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [31:0]  mem_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Behavioural backing store, one 32-bit word per entry.
  logic [31:0] mem [0:4095];

  typedef struct {
    logic        wr;
    logic [13:0] a;
    int          wpat;      // 0 none, 1 word n = n, 2 random
    int          mode;      // 0 ack always, 1 ack every 3rd busy cycle, 2 random
    int          drop_at;   // cycle offset at which the request is withdrawn
    logic        hold;      // keep request high after completion
    logic        from_done; // called while the previous transfer is in DONE
    int          lat;       // expected accept-to-ready latency, 0 = model-timed
    int          idle;
  } vec_t;

  vec_t tbl [7];

  line_mem_bridge #(.ADDR_W(14)) dut (
    .clk(clk), .rst(rst), .chip_select(chip_select), .addr_valid(addr_valid),
    .addr(addr), .data_valid(data_valid), .data_i(data_i), .data_ready(data_ready),
    .data_o(data_o), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic hiz1(input logic v);
    return (v === 1'bz) || (v === 1'b0);
  endfunction

  function automatic logic hiz512(input logic [511:0] v);
    return (v === {512{1'bz}}) || (v === {512{1'b0}});
  endfunction

  // Quiet cycles: no beats, no completion, no read data; acks are noise.
  task automatic idle_chk(input string nm, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      if (mem_req !== 1'b0 || !hiz1(data_ready) || !hiz512(data_o)) errs++;
    end
    chk(nm, errs, 0);
  endtask

  // One line transfer checked against a beat-sequence model.
  task automatic run_txn(input int id, input logic wr, input logic [13:0] a,
                         input logic [511:0] wd, input int mode, input int drop_at,
                         input logic hold, input logic from_done, input int lat);
    logic [511:0] exp_line;
    logic [11:0]  widx;
    logic [13:0]  exp_addr;
    int phase, acks, act, c0, req_err, beat_err, rdy_err;
    logic got_done;
    for (int k = 0; k < 16; k++) begin
      widx = {a[13:6], 4'(k)};
      exp_line[32*k +: 32] = mem[widx];
    end
    chip_select = 1'b1;
    addr_valid  = 1'b1;
    addr        = a;
    data_valid  = wr;
    data_i      = wd;
    if (from_done) tick();
    c0 = cyc; phase = 0; acks = 0; act = 0;
    req_err = 0; beat_err = 0; rdy_err = 0; got_done = 1'b0;
    for (int n = 0; n < 400 && !got_done; n++) begin
      case (mode)
        0:       mem_ack = 1'b1;
        1:       mem_ack = (phase == 1) && (act % 3 == 2);
        default: mem_ack = 1'($urandom_range(0, 1));
      endcase
      mem_rdata = mem[mem_addr[13:2]];
      if (mem_req !== (phase == 1)) req_err++;
      if (phase == 1) begin
        exp_addr = {a[13:6], 4'(acks), 2'b00};
        if (mem_addr !== exp_addr || mem_we !== wr ||
            (wr && mem_wdata !== wd[32*acks +: 32])) beat_err++;
      end
      if (phase == 2) begin
        got_done = 1'b1;
        chk($sformatf("t%0d_ready", id), data_ready, 1'b1);
        if (lat > 0) chk($sformatf("t%0d_latency", id), cyc - c0, lat);
        if (wr) chk($sformatf("t%0d_dout_hiz", id), hiz512(data_o), 1'b1);
        else    chk($sformatf("t%0d_rdata", id), data_o, exp_line);
        if (!hold) begin
          chip_select = 1'b0;
          addr_valid  = 1'b0;
        end
      end else begin
        if (!hiz1(data_ready) || !hiz512(data_o)) rdy_err++;
        if (phase == 0) begin
          phase = 1;
        end else begin
          act++;
          if (mem_ack) begin
            if (wr) mem[{a[13:6], 4'(acks)}] = wd[32*acks +: 32];
            acks++;
            if (acks == 16) phase = 2;
          end
        end
        if (cyc > c0) begin
          addr       = 14'($urandom);
          data_valid = 1'($urandom_range(0, 1));
          data_i     = {16{$urandom}};
        end
        if (drop_at > 0 && cyc - c0 == drop_at) begin
          chip_select = 1'b0;
          addr_valid  = 1'b0;
        end
        tick();
      end
    end
    chk($sformatf("t%0d_completed", id), got_done, 1'b1);
    chk($sformatf("t%0d_mem_req", id), req_err, 0);
    chk($sformatf("t%0d_beats", id), beat_err, 0);
    chk($sformatf("t%0d_no_early_ready", id), rdy_err, 0);
  endtask

  initial begin
    logic [511:0] wd;
    logic         rwr;
    logic [13:0]  ra;

    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    for (int n = 0; n < 16; n++) mem[16 + n] = 32'hA000_0000 + 32'(n);

    tbl[0] = '{wr:1'b0, a:14'h0040, wpat:0, mode:0, drop_at:0, hold:1'b0, from_done:1'b0, lat:17, idle:4};
    tbl[1] = '{wr:1'b1, a:14'h1FC0, wpat:1, mode:0, drop_at:0, hold:1'b0, from_done:1'b0, lat:17, idle:4};
    tbl[2] = '{wr:1'b0, a:14'h1FC0, wpat:0, mode:1, drop_at:0, hold:1'b0, from_done:1'b0, lat:49, idle:4};
    tbl[3] = '{wr:1'b1, a:14'h0000, wpat:2, mode:1, drop_at:0, hold:1'b0, from_done:1'b0, lat:49, idle:4};
    tbl[4] = '{wr:1'b0, a:14'h0040, wpat:0, mode:0, drop_at:5, hold:1'b0, from_done:1'b0, lat:17, idle:20};
    tbl[5] = '{wr:1'b0, a:14'h0000, wpat:0, mode:2, drop_at:0, hold:1'b1, from_done:1'b0, lat:0,  idle:0};
    tbl[6] = '{wr:1'b0, a:14'h3FC0, wpat:0, mode:0, drop_at:0, hold:1'b0, from_done:1'b1, lat:17, idle:4};

    rst = 1'b0; chip_select = 1'b0; addr_valid = 1'b0; addr = 14'h0000;
    data_valid = 1'b0; data_i = {512{1'b0}}; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_mem_we", mem_we, 1'b0);
    chk("reset_mem_addr", mem_addr, 14'h0000);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_ready_hiz", hiz1(data_ready), 1'b1);
    chk("reset_dout_hiz", hiz512(data_o), 1'b1);
    #3 rst = 1'b1;

    // Request without chip_select must be ignored.
    chip_select = 1'b0; addr_valid = 1'b1; addr = 14'h0040; data_valid = 1'b1;
    idle_chk("no_cs_ignored", 10);
    addr_valid = 1'b0;

    for (int i = 0; i < 7; i++) begin
      wd = {512{1'b0}};
      for (int n = 0; n < 16; n++) begin
        if (tbl[i].wpat == 1) wd[32*n +: 32] = 32'(n);
        else if (tbl[i].wpat == 2) wd[32*n +: 32] = $urandom;
      end
      run_txn(i, tbl[i].wr, tbl[i].a, wd, tbl[i].mode, tbl[i].drop_at,
              tbl[i].hold, tbl[i].from_done, tbl[i].lat);
      if (!tbl[i].hold) idle_chk($sformatf("t%0d_idle_after", i), tbl[i].idle);
    end

    // Reset while beat 7 of a read is outstanding.
    chip_select = 1'b1; addr_valid = 1'b1; addr = 14'h0040; data_valid = 1'b0; mem_ack = 1'b1;
    tick();
    for (int b = 0; b < 7; b++) begin
      mem_rdata = mem[mem_addr[13:2]];
      tick();
    end
    chk("rst_mid_beat7_addr", mem_addr, 14'h005C);
    #3 rst = 1'b0;
    #1;
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_mem_addr", mem_addr, 14'h0000);
    chk("rst_mid_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mid_ready_hiz", hiz1(data_ready), 1'b1);
    chip_select = 1'b0; addr_valid = 1'b0;
    tick();
    tick();
    #3 rst = 1'b1;
    idle_chk("rst_mid_no_ready", 6);
    run_txn(20, 1'b0, 14'h0040, {512{1'b0}}, 0, 0, 1'b0, 1'b0, 17);
    idle_chk("t20_idle_after", 3);

    // Randomized transfers with random wait states and stray acks.
    for (int j = 0; j < 16; j++) begin
      rwr = 1'($urandom_range(0, 1));
      ra  = 14'($urandom);
      wd  = {512{1'b0}};
      for (int n = 0; n < 16; n++) wd[32*n +: 32] = $urandom;
      run_txn(100 + j, rwr, ra, wd, 2, 0, 1'b0, 1'b0, 0);
      idle_chk($sformatf("t%0d_idle_after", 100 + j), 1 + int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
